// File: rtl/hsv_core_fetch_sequencer_if.sv
// Bundle for the fetch sequencer: instruction-memory AR/R channels, downstream
// valid/ready entry port and the flush redirect.
interface hsv_core_fetch_sequencer_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic        mem_r_valid;
  logic        mem_r_ready;
  logic [31:0] mem_r_data;
  logic        mem_r_error;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        out_fault;

  modport master (
    input  flush, flush_pc,
    output mem_ar_valid, mem_ar_addr,
    input  mem_ar_ready,
    input  mem_r_valid, mem_r_data, mem_r_error,
    output mem_r_ready,
    input  ready_i,
    output valid_o, out_pc, out_insn, out_fault
  );

  modport slave (
    output flush, flush_pc,
    input  mem_ar_valid, mem_ar_addr,
    output mem_ar_ready,
    output mem_r_valid, mem_r_data, mem_r_error,
    input  mem_r_ready,
    output ready_i,
    input  valid_o, out_pc, out_insn, out_fault
  );
endinterface

// File: rtl/hsv_core_fetch_sequencer.sv
// Sequential instruction fetch front end with in-order response tagging and flush redirect.
// Optional HSV_CORE_FETCH_HALT_ON_FAULT_EN: stop issuing after a delivered fault until the next flush.
module hsv_core_fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 4
) (
  input logic                        clk_core,
  input logic                        rst_core_n,
  hsv_core_fetch_sequencer_if.master bus
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic          stale_ar_reg, stale_ar_next;
  logic          ar_valid_reg, ar_valid_next;
  logic [31:0]   ar_addr_reg, ar_addr_next;
  logic          out_valid_reg, out_valid_next;
  logic [31:0]   out_pc_reg, out_pc_next;
  logic [31:0]   out_insn_reg, out_insn_next;
  logic          out_fault_reg, out_fault_next;
  logic          halt_reg;
`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
  logic          halt_next;
`else
  assign halt_reg = 1'b0;
`endif

  logic          ar_fire, r_fire, r_ready, drop, load, issue_ok;
  logic [31:0]   redirect_pc;

  // While discarding, responses never reach the output register, so ignore downstream stall.
  assign r_ready     = (discard_reg != '0) | ~out_valid_reg | bus.ready_i;
  assign ar_fire     = ar_valid_reg & bus.mem_ar_ready;
  assign r_fire      = bus.mem_r_valid & r_ready;
  assign drop        = (discard_reg != '0) | bus.flush;
  assign load        = r_fire & ~drop;
  assign issue_ok    = ~ar_valid_reg & ~bus.flush & (inflight_reg < CNT_MAX) & ~halt_reg;
  assign redirect_pc = bus.flush_pc & 32'hFFFF_FFFC;

  always_comb begin
    fetch_pc_next  = fetch_pc_reg;
    resp_pc_next   = resp_pc_reg;
    inflight_next  = inflight_reg;
    discard_next   = discard_reg;
    stale_ar_next  = stale_ar_reg & ~ar_fire;
    ar_valid_next  = ar_valid_reg;
    ar_addr_next   = ar_addr_reg;
    out_valid_next = out_valid_reg;
    out_pc_next    = out_pc_reg;
    out_insn_next  = out_insn_reg;
    out_fault_next = out_fault_reg;
`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
    halt_next      = halt_reg;
`endif

    if (ar_fire && !r_fire)
      inflight_next = inflight_reg + CNT_ONE;
    else if (!ar_fire && r_fire)
      inflight_next = inflight_reg - CNT_ONE;

    // A stale AR accepted now owes one more response to throw away.
    discard_next = discard_reg
                 + ((ar_fire && stale_ar_reg) ? CNT_ONE : '0)
                 - ((r_fire && discard_reg != '0) ? CNT_ONE : '0);

    if (ar_fire) begin
      ar_valid_next = 1'b0;
    end else if (issue_ok) begin
      ar_valid_next = 1'b1;
      ar_addr_next  = fetch_pc_reg;
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    if (load) begin
      out_valid_next = 1'b1;
      out_pc_next    = resp_pc_reg;
      out_insn_next  = bus.mem_r_data;
      out_fault_next = bus.mem_r_error;
      resp_pc_next   = resp_pc_reg + 32'd4;
`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
      if (bus.mem_r_error)
        halt_next = 1'b1;
`endif
    end else if (out_valid_reg && bus.ready_i) begin
      out_valid_next = 1'b0;
    end

    // Redirect overrides everything but the counter bookkeeping; a pending AR is left untouched.
    if (bus.flush) begin
      fetch_pc_next  = redirect_pc;
      resp_pc_next   = redirect_pc;
      out_valid_next = 1'b0;
      discard_next   = inflight_next;
      stale_ar_next  = ar_valid_reg & ~ar_fire;
`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
      halt_next      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      fetch_pc_reg  <= RESET_PC;
      resp_pc_reg   <= RESET_PC;
      inflight_reg  <= '0;
      discard_reg   <= '0;
      stale_ar_reg  <= 1'b0;
      ar_valid_reg  <= 1'b0;
      ar_addr_reg   <= RESET_PC;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_insn_reg  <= '0;
      out_fault_reg <= 1'b0;
    end else begin
      fetch_pc_reg  <= fetch_pc_next;
      resp_pc_reg   <= resp_pc_next;
      inflight_reg  <= inflight_next;
      discard_reg   <= discard_next;
      stale_ar_reg  <= stale_ar_next;
      ar_valid_reg  <= ar_valid_next;
      ar_addr_reg   <= ar_addr_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_insn_reg  <= out_insn_next;
      out_fault_reg <= out_fault_next;
    end
  end

`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n)
      halt_reg <= 1'b0;
    else
      halt_reg <= halt_next;
  end
`endif

  assign bus.mem_ar_valid = ar_valid_reg;
  assign bus.mem_ar_addr  = ar_addr_reg;
  assign bus.mem_r_ready  = r_ready;
  assign bus.valid_o      = out_valid_reg;
  assign bus.out_pc       = out_pc_reg;
  assign bus.out_insn     = out_insn_reg;
  assign bus.out_fault    = out_fault_reg;
endmodule

// File: tb/tb_hsv_core_fetch_sequencer.sv
// Bench for hsv_core_fetch_sequencer: an address-indexed memory model answers reads in order and the
// delivered stream is compared against the PC sequence implied by reset/flush redirects.
module tb_hsv_core_fetch_sequencer;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam int          MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsv_core_fetch_sequencer_if bus();

  hsv_core_fetch_sequencer #(
    .RESET_PC       (RPC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_core  (clk),
    .rst_core_n(rst_n),
    .bus       (bus)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] memq[$];
  int          outstanding = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = RPC;
  bit          r_pending = 1'b0;
  bit          prev_ar_pend = 1'b0;
  logic [31:0] prev_ar_addr = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_insn = '0;
  logic        prev_fault = 1'b0;
  bit          blk_en = 1'b0;
  logic [31:0] blk_addr = '0;

  // Memory contents and error map, indexed by word address.
  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return (a == 32'h0000_0108) || (a[6:2] == 5'd19);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample #1 later, update the reference model.
  task automatic cycle(input int p_ar, input int p_r, input int p_rdy,
                       input bit do_flush, input logic [31:0] fpc);
    bit arf, rf, of;
    @(negedge clk);
    if (blk_en)
      bus.mem_ar_ready = (bus.mem_ar_addr != blk_addr);
    else
      bus.mem_ar_ready = (int'($urandom_range(99)) < p_ar);
    if (memq.size() > 0 && (r_pending || int'($urandom_range(99)) < p_r)) begin
      bus.mem_r_valid = 1'b1;
      bus.mem_r_data  = data_fn(memq[0]);
      bus.mem_r_error = err_fn(memq[0]);
    end else begin
      bus.mem_r_valid = 1'b0;
      bus.mem_r_data  = '0;
      bus.mem_r_error = 1'b0;
    end
    bus.ready_i  = (int'($urandom_range(99)) < p_rdy);
    bus.flush    = do_flush;
    bus.flush_pc = fpc;
    #1;
    if (prev_ar_pend) begin
      chk("ar_valid_hold", 32'(bus.mem_ar_valid), 32'd1);
      chk("ar_addr_hold", bus.mem_ar_addr, prev_ar_addr);
    end
    if (prev_stall) begin
      chk("out_valid_hold", 32'(bus.valid_o), 32'd1);
      chk("out_pc_hold", bus.out_pc, prev_pc);
      chk("out_insn_hold", bus.out_insn, prev_insn);
      chk("out_fault_hold", 32'(bus.out_fault), 32'(prev_fault));
    end
    arf = bus.mem_ar_valid & bus.mem_ar_ready;
    rf  = bus.mem_r_valid & bus.mem_r_ready;
    of  = bus.valid_o & bus.ready_i;
    if (of) begin
      chk("out_pc", bus.out_pc, exp_pc);
      chk("out_insn", bus.out_insn, data_fn(exp_pc));
      chk("out_fault", 32'(bus.out_fault), 32'(err_fn(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (rf) begin
      void'(memq.pop_front());
      outstanding--;
      r_pending = 1'b0;
    end else begin
      r_pending = bus.mem_r_valid;
    end
    if (arf) begin
      memq.push_back(bus.mem_ar_addr);
      outstanding++;
      chk("inflight_limit", 32'(outstanding <= MAXO), 32'd1);
    end
    if (do_flush)
      exp_pc = fpc & 32'hFFFF_FFFC;
    prev_ar_pend = bus.mem_ar_valid & ~bus.mem_ar_ready;
    prev_ar_addr = bus.mem_ar_addr;
    prev_stall   = bus.valid_o & ~bus.ready_i & ~do_flush;
    prev_pc      = bus.out_pc;
    prev_insn    = bus.out_insn;
    prev_fault   = bus.out_fault;
  endtask

  initial begin
    bus.mem_ar_ready = 1'b0;
    bus.mem_r_valid  = 1'b0;
    bus.mem_r_data   = '0;
    bus.mem_r_error  = 1'b0;
    bus.ready_i      = 1'b0;
    bus.flush        = 1'b0;
    bus.flush_pc     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_ar_valid", 32'(bus.mem_ar_valid), 32'd0);
    chk("rst_ar_addr", bus.mem_ar_addr, RPC);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_insn", bus.out_insn, 32'd0);
    chk("rst_out_fault", 32'(bus.out_fault), 32'd0);
    chk("rst_r_ready", 32'(bus.mem_r_ready), 32'd1);

    // First AR one cycle after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("first_ar_valid", 32'(bus.mem_ar_valid), 32'd1);
    chk("first_ar_addr", bus.mem_ar_addr, RPC);

    // Free-flowing stream from RESET_PC, including the fault at 0x108.
    repeat (40) cycle(100, 100, 100, 1'b0, 32'h0);
`ifdef HSV_CORE_FETCH_HALT_ON_FAULT_EN
    chk("halt_no_ar", 32'(bus.mem_ar_valid), 32'd0);
    chk("halt_drained", 32'(outstanding), 32'd0);
`else
    chk("stream_progress", 32'(delivered >= 15), 32'd1);
`endif

    // Withhold responses: issue must stop at MAX_OUTSTANDING.
    for (int i = 0; i < 50 && outstanding != 0; i++) cycle(0, 100, 100, 1'b0, 32'h0);
    chk("drain_before_full", 32'(outstanding), 32'd0);
    cycle(0, 0, 100, 1'b1, 32'h0000_0400);
    repeat (20) cycle(100, 0, 100, 1'b0, 32'h0);
    chk("full_inflight", 32'(outstanding), 32'(MAXO));
    chk("full_no_ar", 32'(bus.mem_ar_valid), 32'd0);

    // Three reads in flight, then redirect to 0x2000.
    for (int i = 0; i < 20 && outstanding != 3; i++) cycle(0, 100, 100, 1'b0, 32'h0);
    chk("three_inflight", 32'(outstanding), 32'd3);
    cycle(0, 0, 100, 1'b1, 32'h0000_2000);
    repeat (30) cycle(100, 100, 100, 1'b0, 32'h0);

    // Flush while the AR to 0x10C is stalled.
    blk_en   = 1'b1;
    blk_addr = 32'h0000_010C;
    cycle(100, 100, 100, 1'b1, 32'h0000_010C);
    for (int i = 0; i < 40 && !(bus.mem_ar_valid && bus.mem_ar_addr == blk_addr); i++)
      cycle(100, 100, 100, 1'b0, 32'h0);
    chk("stall_ar_addr", bus.mem_ar_addr, 32'h0000_010C);
    cycle(100, 100, 100, 1'b1, 32'h0000_3000);
    repeat (6) cycle(100, 100, 100, 1'b0, 32'h0);
    chk("stale_ar_valid", 32'(bus.mem_ar_valid), 32'd1);
    chk("stale_ar_addr", bus.mem_ar_addr, 32'h0000_010C);
    blk_en = 1'b0;
    repeat (20) cycle(100, 100, 100, 1'b0, 32'h0);

    // Downstream stall for 10 cycles mid-stream.
    repeat (10) cycle(100, 100, 0, 1'b0, 32'h0);
    chk("stall_valid_o", 32'(bus.valid_o), 32'd1);
    chk("stall_r_ready", 32'(bus.mem_r_ready), 32'd0);
    repeat (20) cycle(100, 100, 100, 1'b0, 32'h0);

    // Address wrap with ignored low bits, then back-to-back flushes.
    cycle(100, 100, 100, 1'b1, 32'hFFFF_FFF6);
    repeat (20) cycle(100, 100, 100, 1'b0, 32'h0);
    cycle(100, 100, 100, 1'b1, 32'h0000_5000);
    cycle(100, 100, 100, 1'b1, 32'h0000_6003);
    repeat (20) cycle(100, 100, 100, 1'b0, 32'h0);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      bit f;
      f = (int'($urandom_range(99)) < 2);
      cycle(70, 60, 70, f, $urandom & 32'h0000_FFFF);
    end
    chk("total_delivered", 32'(delivered > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hsv_core_fetch_sequencer.md
# hsv_core_fetch_sequencer

Instruction-fetch front end that issues sequential 32-bit fetch requests to the instruction memory port, tracks outstanding reads, tags each returned word with its PC, and presents `{pc, insn, fault}` through a valid/ready output. It sits directly upstream of the fetch/decode FIFO and drives that FIFO's write side. A `flush` redirect restarts fetching at a new PC and silently drops every response still in flight.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unreturned reads; must be ≥1.

- `clk_core` in 1: core clock; all state on rising edge.
- `rst_core_n` in 1: asynchronous, active-low reset.
- `flush` in 1: redirect request, one-cycle pulse.
- `flush_pc` in 32: new fetch PC, sampled when `flush`=1; bits [1:0] ignored (treated 0).
- `mem_ar_valid` out 1, `mem_ar_ready` in 1, `mem_ar_addr` out 32: read-address channel.
- `mem_r_valid` in 1, `mem_r_ready` out 1, `mem_r_data` in 32, `mem_r_error` in 1: read-data channel; responses return in request order.
- `ready_i` in 1, `valid_o` out 1: downstream handshake.
- `out_pc` out 32, `out_insn` out 32, `out_fault` out 1: fetched entry.

## Operation
- State: `fetch_pc`, `resp_pc`, `inflight` and `discard` counters (`$clog2(MAX_OUTSTANDING+1)` bits), `stale_ar` flag, registered `mem_ar_valid`/`mem_ar_addr`, output register.
- Reset values: `fetch_pc`=`resp_pc`=`RESET_PC`; `mem_ar_valid`=0, `mem_ar_addr`=`RESET_PC`; `valid_o`=0, `out_pc`=0, `out_insn`=0, `out_fault`=0; counters 0; `stale_ar`=0.
- Issue: when `mem_ar_valid`=0, `flush`=0 and `inflight` < `MAX_OUTSTANDING`, register `mem_ar_valid`=1, `mem_ar_addr`=`fetch_pc`, `fetch_pc`+=4 (wraps mod 2^32). AR handshake: `inflight`+1, `mem_ar_valid` drops next cycle.
- AR stability: once raised, `mem_ar_valid` and `mem_ar_addr` stay constant until accepted, including across `flush`.
- Response: `mem_r_ready` = (`discard`≠0) | ~`valid_o` | `ready_i`. R handshake: `inflight`−1. If `discard`≠0 or `flush`=1: drop, `discard`−1 (when nonzero). Otherwise load output register `{resp_pc, mem_r_data, mem_r_error}`, `valid_o`=1, `resp_pc`+=4.
- Output: `valid_o` clears on downstream handshake with no new load; held data stable while `valid_o & ~ready_i`.
- Flush: `fetch_pc`=`resp_pc`=`flush_pc`; `valid_o`=0; `discard` = `inflight` after this cycle's AR/R events (simultaneous AR accept counted, simultaneous R return excluded); if `mem_ar_valid` is unaccepted after this cycle, `stale_ar`=1. When a stale AR is accepted: `discard`+1, `stale_ar`=0. Flush has priority over all same-cycle updates except counter bookkeeping.
- Back-to-back flushes: each recomputes `discard` from live `inflight`; latest `flush_pc` wins.

## Timing
- Reset release at cycle 0 → `mem_ar_valid`=1, `mem_ar_addr`=`RESET_PC` at cycle 1.
- Issue rate: one AR per 2 cycles maximum (valid register drops after accept).
- R handshake at cycle M → `valid_o` at M+1.
- `flush` at N, no stale AR → `mem_ar_addr`=`flush_pc` valid at N+1. With stale AR pending → new AR the cycle after the stale one is accepted.
- Full: `inflight`=`MAX_OUTSTANDING` blocks issue; resumes the cycle after a response returns.
- Output stall backpressures `mem_r_ready` combinationally only when not discarding.

## Configuration
- `HSV_CORE_FETCH_HALT_ON_FAULT_EN` defined: after a non-discarded response with `mem_r_error`=1 is loaded, no further ARs issue until the next `flush`; already-issued reads still complete and are delivered.
- Undefined: faults are only flagged on `out_fault`; sequential fetching continues.

## Test plan
- Reset, `RESET_PC`=`32'h100`, memory always ready, `ready_i`=1 → outputs pc `100,104,108…` with matching data, in order, none lost.
- Memory accepts 4 ARs, withholds R; `MAX_OUTSTANDING`=4 → no 5th AR until first R returns.
- `ready_i`=0 for 10 cycles mid-stream → `valid_o` held, `out_*` unchanged, `mem_r_ready`=0, no drop/duplication after release.
- 3 reads in flight, `flush` with `flush_pc`=`32'h2000` → 3 responses dropped, first output `out_pc`=`2000`.
- `flush` while AR to `0x10C` is stalled → `mem_ar_addr` stays `0x10C` until accepted, its response dropped, then AR to `flush_pc`.
- Response with `mem_r_error`=1 at pc `0x108` → `out_fault`=1 for that entry; with `HSV_CORE_FETCH_HALT_ON_FAULT_EN` no new AR until `flush`, without it fetch continues at `0x10C+`.
